pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised fetch program counter for the pipelined MIPS core; successor to the plain stall/reset PC register.
//  Selects next PC from sequential step, branch/jump redirect, exception entry and eret return.
//  Buffers a redirect that arrives while fetch is stalled and applies it on release.
//  Sits at the F stage, feeding IM and the F/D pipeline register.
// PARAMETERS
//  WIDTH      32            PC width in bits
//  STEP       4             sequential increment in bytes
//  RESET_VEC  32'h0000_3000 PC value after reset
//  EXC_VEC    32'h0000_4180 exception handler entry
//  IM_BASE    32'h0000_3000 lowest legal fetch address (PC_ADEL_EN only)
//  IM_LIMIT   32'h0000_6FFF highest legal fetch address, inclusive (PC_ADEL_EN only)
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  reset         in   1      synchronous, active-low reset
//  stall         in   1      hold PC; branch redirect is buffered
//  br_valid      in   1      branch/jump taken this cycle
//  br_target     in   WIDTH  branch/jump destination
//  exc_req       in   1      take exception; bypasses stall
//  eret          in   1      return from exception; bypasses stall
//  epc           in   WIDTH  eret return address
//  pc            out  WIDTH  current fetch address
//  pc_next_seq   out  WIDTH  pc + STEP, combinational, wraps mod 2^WIDTH
//  pc_src        out  3      source of current pc (pc_pkg::pc_src_e)
//  redir_pending out  1      a buffered branch redirect is held
//  fetch_adel    out  1      current pc is misaligned/out of range
// BEHAVIOUR
//  One clock, synchronous active-low reset: reset==0 at posedge -> pc=RESET_VEC,
//   pc_src=SRC_RST, pending cleared (state IDLE), fetch_adel=0. Reset wins over every input.
//  Next-PC priority each posedge (reset==1):
//   1 exc_req                   -> pc=EXC_VEC, pc_src=SRC_EXC, pending cleared; ignores stall
//   2 eret                      -> pc=epc, pc_src=SRC_ERET, pending cleared; ignores stall
//   3 stall                     -> pc held; if br_valid, pend_target<=br_target, state->PEND
//   4 state PEND (stall==0)     -> pc=pend_target, pc_src=SRC_PEND, state->IDLE; br_valid ignored
//   5 br_valid                  -> pc=br_target, pc_src=SRC_BR
//   6 otherwise                 -> pc=pc+STEP, pc_src=SRC_SEQ
//  Redirect buffer FSM: IDLE --(stall & br_valid)--> PEND; PEND --(stall & br_valid)--> PEND with
//   target overwritten (latest wins); PEND --(!stall)--> IDLE; any exc_req/eret -> IDLE.
//  redir_pending = (state==PEND); registered, reset 0.
//  Latency: redirect visible on pc the cycle after acceptance; buffered redirect one cycle after stall drops.
//  Sum pc+STEP truncated to WIDTH (0xFFFF_FFFC+4 -> 0x0000_0000), no flag.
//  exc_req and eret both high: exc_req wins.
// CONFIGURATION
//  PC_ADEL_EN defined: fetch_adel registered alongside pc, =1 when pc[1:0]!=0 or pc<IM_BASE or
//   pc>IM_LIMIT, evaluated on the value being loaded; reset 0.
//  PC_ADEL_EN undefined: fetch_adel tied 0; IM_BASE/IM_LIMIT unused.
// STRUCTURE
//  pc_pkg: pc_src_e {SRC_RST=0,SRC_SEQ,SRC_BR,SRC_PEND,SRC_ERET,SRC_EXC}, pend_state_e {IDLE,PEND},
//   default RESET_VEC/EXC_VEC constants shared with CP0 and testbench.
//  Sub-module pc_redirect_buf: pending FSM + pend_target register; pc_unit holds priority mux and pc.
// TESTING
//  Reset low 2 cycles, release, no redirects -> pc 0x3000, 0x3004, 0x3008; pc_src=SEQ.
//  pc=0x3008, stall 3 cycles -> pc stays 0x3008, redir_pending=0, pc_src unchanged.
//  pc=0x3010, stall=1 with br_valid target 0x3100, then 0x3200, stall drops -> pc 0x3200, pc_src=PEND, pending 0.
//  PEND held, exc_req=1 while stall=1 -> next pc 0x4180, pc_src=EXC, redir_pending=0; then eret epc=0x3014 -> pc 0x3014.
//  exc_req=1, eret=1, br_valid=1 same cycle -> pc 0x4180; reset low during PEND -> pc 0x3000, pending 0.
//  PC_ADEL_EN: br_target 0x3002 -> fetch_adel=1; 0x7000 -> 1; 0x3004 -> 0; undefined -> always 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch PC, also used by CP0 and the bench.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_RST  = 3'd0,
      SRC_SEQ  = 3'd1,
      SRC_BR   = 3'd2,
      SRC_PEND = 3'd3,
      SRC_ERET = 3'd4,
      SRC_EXC  = 3'd5
   } pc_src_e;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } pend_state_e;

   localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] PC_IM_BASE   = 32'h0000_3000;
   localparam logic [31:0] PC_IM_LIMIT  = 32'h0000_6FFF;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a branch redirect that arrives while fetch is stalled until the stall releases.
//  state | meaning
//  IDLE  | no redirect held
//  PEND  | pend_target holds a redirect to apply when stall drops
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             flush,
   output logic             redir_pending,
   output logic [WIDTH-1:0] pend_target
);

   pend_state_e      state_q;
   logic [WIDTH-1:0] target_q;

   // A later stalled redirect overwrites an earlier one: only the newest is architecturally live.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         target_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else if (stall) begin
         if (br_valid) begin
            state_q  <= PEND;
            target_q <= br_target;
         end
      end else begin
         state_q <= IDLE;
      end
   end

   assign redir_pending = (state_q == PEND);
   assign pend_target   = target_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: next-PC priority mux and PC register.
// Define PC_ADEL_EN to register a fetch address-error flag alongside pc.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      STEP      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC)
`ifdef PC_ADEL_EN
   ,
   parameter logic [WIDTH-1:0] IM_BASE   = WIDTH'(PC_IM_BASE),
   parameter logic [WIDTH-1:0] IM_LIMIT  = WIDTH'(PC_IM_LIMIT)
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             exc_req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next_seq,
   output logic [2:0]       pc_src,
   output logic             redir_pending,
   output logic             fetch_adel
);

   logic [WIDTH-1:0] pc_q, pc_d, seq_pc, pend_target;
   pc_src_e          src_q, src_d;

   assign seq_pc = pc_q + WIDTH'(STEP);

   pc_redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .br_valid      (br_valid),
      .br_target     (br_target),
      .flush         (exc_req | eret),
      .redir_pending (redir_pending),
      .pend_target   (pend_target)
   );

   always_comb begin
      pc_d  = seq_pc;
      src_d = SRC_SEQ;
      if (exc_req) begin
         pc_d  = EXC_VEC;
         src_d = SRC_EXC;
      end else if (eret) begin
         pc_d  = epc;
         src_d = SRC_ERET;
      end else if (stall) begin
         pc_d  = pc_q;
         src_d = src_q;
      end else if (redir_pending) begin
         pc_d  = pend_target;
         src_d = SRC_PEND;
      end else if (br_valid) begin
         pc_d  = br_target;
         src_d = SRC_BR;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q  <= RESET_VEC;
         src_q <= SRC_RST;
      end else begin
         pc_q  <= pc_d;
         src_q <= src_d;
      end
   end

`ifdef PC_ADEL_EN
   logic adel_q;

   // Flag is computed from the value being loaded so it lines up with pc.
   always_ff @(posedge clk) begin
      if (!reset) begin
         adel_q <= 1'b0;
      end else begin
         adel_q <= (pc_d[1:0] != 2'b00) || (pc_d < IM_BASE) || (pc_d > IM_LIMIT);
      end
   end

   assign fetch_adel = adel_q;
`else
   assign fetch_adel = 1'b0;
`endif

   assign pc          = pc_q;
   assign pc_next_seq = seq_pc;
   assign pc_src      = src_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed vectors for pc_unit; driver queues expected state, a monitor compares after each posedge.
module tb_pc_unit;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall, br_valid, exc_req, eret;
   logic [31:0] br_target, epc;
   logic [31:0] pc, pc_next_seq;
   logic [2:0]  pc_src;
   logic        redir_pending, fetch_adel;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  src;
      logic        pend;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   drv_done = 1'b0;

   pc_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .br_valid      (br_valid),
      .br_target     (br_target),
      .exc_req       (exc_req),
      .eret          (eret),
      .epc           (epc),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .pc_src        (pc_src),
      .redir_pending (redir_pending),
      .fetch_adel    (fetch_adel)
   );

   always #5 clk = ~clk;

   function automatic logic exp_adel(input logic [31:0] p);
`ifdef PC_ADEL_EN
      return (p[1:0] != 2'b00) || (p < 32'h0000_3000) || (p > 32'h0000_6FFF);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs and queue the state expected after the next posedge.
   task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                       input logic exc, input logic er, input logic [31:0] ep,
                       input logic [31:0] e_pc, input pc_src_e e_src, input logic e_pend);
      exp_t e;
      @(negedge clk);
      reset = rst; stall = stl; br_valid = br; br_target = tgt;
      exc_req = exc; eret = er; epc = ep;
      e.pc = e_pc; e.src = e_src; e.pend = e_pend;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_src", {29'd0, pc_src}, {29'd0, e.src});
            chk("redir_pending", {31'd0, redir_pending}, {31'd0, e.pend});
            chk("pc_next_seq", pc_next_seq, e.pc + 32'd4);
            chk("fetch_adel", {31'd0, fetch_adel}, {31'd0, exp_adel(e.pc)});
         end
      end
   end

   initial begin : driver
      reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
      exc_req = 1'b0; eret = 1'b0; epc = '0;
      //   rst stl br  tgt           exc er  epc           pc            src       pend
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, SRC_RST,  0);
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, SRC_RST,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, SRC_SEQ,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, SRC_SEQ,  0);
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 32'h0,     0, 0, 32'h0,        32'h0000_3008, SRC_SEQ,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, SRC_SEQ,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, SRC_SEQ,  0);
      // buffered redirect, latest target wins, br_valid on release ignored
      step(1, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3010, SRC_SEQ,  1);
      step(1, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3010, SRC_SEQ,  1);
      step(1, 0, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3200, SRC_PEND, 0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3204, SRC_SEQ,  0);
      step(1, 0, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3400, SRC_BR,   0);
      // exception while stalled with a redirect pending, then eret under stall
      step(1, 1, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3400, SRC_BR,   1);
      step(1, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, SRC_EXC,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, SRC_SEQ,  0);
      step(1, 1, 0, 32'h0,        0, 1, 32'h3014,     32'h0000_3014, SRC_ERET, 0);
      step(1, 0, 1, 32'h3800,     1, 1, 32'h3018,     32'h0000_4180, SRC_EXC,  0);
      // eret clears a pending redirect; it must not be applied afterwards
      step(1, 1, 1, 32'h3700,     0, 0, 32'h0,        32'h0000_4180, SRC_EXC,  1);
      step(1, 1, 0, 32'h0,        0, 1, 32'h3020,     32'h0000_3020, SRC_ERET, 0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3024, SRC_SEQ,  0);
      // reset during PEND
      step(1, 1, 1, 32'h3600,     0, 0, 32'h0,        32'h0000_3024, SRC_SEQ,  1);
      step(0, 1, 1, 32'h3600,     0, 0, 32'h0,        32'h0000_3000, SRC_RST,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, SRC_SEQ,  0);
      // address-error candidates and wraparound
      step(1, 0, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3002, SRC_BR,   0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3006, SRC_SEQ,  0);
      step(1, 0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, SRC_BR,   0);
      step(1, 0, 1, 32'h3004,     0, 0, 32'h0,        32'h0000_3004, SRC_BR,   0);
      step(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'hFFFF_FFFC, SRC_BR,   0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, SRC_SEQ,  0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0004, SRC_SEQ,  0);
      drv_done = 1'b1;
   end

   initial begin : finisher
      int budget;
      budget = 0;
      wait (drv_done);
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule
